// File: rtl/fpmul_pipe_if.sv
// Handshake and data bundle for the pipelined floating-point multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface fpmul_pipe_if #(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] product;
   logic         overflow;
   logic         underflow;
   logic         inexact;
   logic         invalid;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, overflow, underflow, inexact, invalid
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, overflow, underflow, inexact, invalid
   );
endinterface

// File: rtl/fpmul_pipe.sv
// Four-stage pipelined floating-point multiplier.
// S1 registers operands, S2 unpacks and multiplies significands, S3 normalises and
// rounds to nearest-even, S4 is the output register. Subnormals are flushed to zero
// on input and tiny results are flushed to zero on output. One global advance
// signal stalls every stage together when the consumer back-pressures.
module fpmul_pipe #(
   parameter int unsigned EXP_W = 5,
   parameter int unsigned MAN_W = 10
) (
   input logic         clk_i,
   input logic         rst_ni,
   fpmul_pipe_if.slave bus
);
   localparam int unsigned W    = 1 + EXP_W + MAN_W;
   localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int unsigned EMAX = (1 << EXP_W) - 1;
   localparam int unsigned PW   = 2 * MAN_W + 2;
   localparam int unsigned XW   = EXP_W + 2;

   localparam logic [EXP_W-1:0]     ExpMax = EXP_W'(EMAX);
   localparam logic signed [XW-1:0] BiasX  = XW'(BIAS);
   localparam logic signed [XW-1:0] EmaxX  = XW'(EMAX);
   localparam logic [W-1:0]         QNaN   = {1'b0, ExpMax, 1'b1, {(MAN_W-1){1'b0}}};

   // ---------------------------------------------------------------- control
   logic advance;
   logic s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;

   assign advance      = !out_valid_q || bus.out_ready;
   assign bus.in_ready = advance;

   // Valid bits move one stage per advance; reset empties the whole pipe.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
      end else if (advance) begin
         s1_valid_q <= bus.in_valid;
         s2_valid_q <= s1_valid_q;
         s3_valid_q <= s2_valid_q;
      end
   end

   // ---------------------------------------------------------------- S1
   logic [W-1:0] s1_a_q, s1_b_q;

   // Operand capture; contents are only meaningful when s1_valid_q is set.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         s1_a_q <= bus.a;
         s1_b_q <= bus.b;
      end
   end

   // ---------------------------------------------------------------- S2
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_man, b_man;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic             res_sign;

   assign {a_sign, a_exp, a_man} = s1_a_q;
   assign {b_sign, b_exp, b_man} = s1_b_q;

   // Exponent zero covers both true zero and subnormals (treated as zero).
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (a_exp == ExpMax) && (a_man == '0);
   assign b_inf  = (b_exp == ExpMax) && (b_man == '0);
   assign a_nan  = (a_exp == ExpMax) && (a_man != '0);
   assign b_nan  = (b_exp == ExpMax) && (b_man != '0);
   assign a_snan = a_nan && !a_man[MAN_W-1];
   assign b_snan = b_nan && !b_man[MAN_W-1];

   assign res_sign = a_sign ^ b_sign;

   logic                 s2_special_d, s2_inv_d;
   logic [W-1:0]         s2_spec_d;
   logic [PW-1:0]        s2_prod_d;
   logic signed [XW-1:0] s2_exp_d;

   // Special-case classification; a hit here bypasses the arithmetic result in S3.
   always_comb begin
      s2_special_d = 1'b1;
      s2_inv_d     = 1'b0;
      s2_spec_d    = '0;
      if (a_nan || b_nan) begin
         s2_spec_d = QNaN;
         s2_inv_d  = a_snan || b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         s2_spec_d = QNaN;
         s2_inv_d  = 1'b1;
      end else if (a_inf || b_inf) begin
         s2_spec_d = {res_sign, ExpMax, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         s2_spec_d = {res_sign, {(W-1){1'b0}}};
      end else begin
         s2_special_d = 1'b0;
      end
   end

   assign s2_prod_d = PW'({1'b1, a_man}) * PW'({1'b1, b_man});
   // Two extra bits keep the biased sum from wrapping in either direction.
   assign s2_exp_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BiasX;

   logic                 s2_sign_q, s2_special_q, s2_inv_q;
   logic [W-1:0]         s2_spec_q;
   logic [PW-1:0]        s2_prod_q;
   logic signed [XW-1:0] s2_exp_q;

   // S2 datapath register.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         s2_sign_q    <= res_sign;
         s2_special_q <= s2_special_d;
         s2_inv_q     <= s2_inv_d;
         s2_spec_q    <= s2_spec_d;
         s2_prod_q    <= s2_prod_d;
         s2_exp_q     <= s2_exp_d;
      end
   end

   // ---------------------------------------------------------------- S3
   logic [PW-1:0]        norm;
   logic [MAN_W-1:0]     mant;
   logic                 guard, sticky, round_up;
   logic [MAN_W:0]       mant_r;
   logic signed [XW-1:0] inc_norm, inc_round, exp_fin;
   logic [W-1:0]         s3_res_d;
   logic                 s3_ovf_d, s3_unf_d, s3_inx_d, s3_inv_d;
   logic                 unused_norm_msb;

   // Normalise to a leading one at bit PW-1, round to nearest-even, then range-check.
   always_comb begin
      norm      = s2_prod_q[PW-1] ? s2_prod_q : (s2_prod_q << 1);
      mant      = norm[PW-2 -: MAN_W];
      guard     = norm[MAN_W];
      sticky    = |norm[MAN_W-1:0];
      round_up  = guard && (sticky || mant[0]);
      // A carry out of mant_r leaves its low bits all zero, i.e. 1.0 at exponent+1.
      mant_r    = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
      inc_norm  = {{(XW-1){1'b0}}, s2_prod_q[PW-1]};
      inc_round = {{(XW-1){1'b0}}, mant_r[MAN_W]};
      exp_fin   = s2_exp_q + inc_norm + inc_round;

      s3_res_d = {s2_sign_q, exp_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
      s3_ovf_d = 1'b0;
      s3_unf_d = 1'b0;
      s3_inx_d = guard || sticky;
      s3_inv_d = 1'b0;
      if (s2_special_q) begin
         s3_res_d = s2_spec_q;
         s3_inx_d = 1'b0;
         s3_inv_d = s2_inv_q;
      end else if (exp_fin >= EmaxX) begin
         s3_res_d = {s2_sign_q, ExpMax, {MAN_W{1'b0}}};
         s3_ovf_d = 1'b1;
         s3_inx_d = 1'b1;
      end else if (exp_fin[XW-1] || (exp_fin == '0)) begin
         s3_res_d = {s2_sign_q, {(W-1){1'b0}}};
         s3_unf_d = 1'b1;
         s3_inx_d = 1'b1;
      end
   end

   assign unused_norm_msb = norm[PW-1];

   logic [W-1:0] s3_res_q;
   logic         s3_ovf_q, s3_unf_q, s3_inx_q, s3_inv_q;

   // S3 datapath register.
   always_ff @(posedge clk_i) begin
      if (advance) begin
         s3_res_q <= s3_res_d;
         s3_ovf_q <= s3_ovf_d;
         s3_unf_q <= s3_unf_d;
         s3_inx_q <= s3_inx_d;
         s3_inv_q <= s3_inv_d;
      end
   end

   // ---------------------------------------------------------------- S4
   logic [W-1:0] product_q;
   logic         ovf_q, unf_q, inx_q, inv_q;

   // Output register; data only reloads on a valid beat so it never shows bubbles.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_valid_q <= 1'b0;
         product_q   <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         inx_q       <= 1'b0;
         inv_q       <= 1'b0;
      end else if (advance) begin
         out_valid_q <= s3_valid_q;
         if (s3_valid_q) begin
            product_q <= s3_res_q;
            ovf_q     <= s3_ovf_q;
            unf_q     <= s3_unf_q;
            inx_q     <= s3_inx_q;
            inv_q     <= s3_inv_q;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.inexact   = inx_q;
   assign bus.invalid   = inv_q;
endmodule

// File: tb/tb_fpmul_pipe.sv
// Scoreboard bench for fpmul_pipe: the driver pushes expected results on acceptance,
// an independent monitor pops and compares on every output transfer.
module tb_fpmul_pipe;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpmul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();
   fpmul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32 ();

   fpmul_pipe #(.EXP_W(5), .MAN_W(10)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
   fpmul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));

   typedef struct {
      logic [15:0] prod;
      logic [3:0]  flags;  // {overflow, underflow, inexact, invalid}
      int          acc_cyc;
      int          acc_stalls;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stalls = 0;
   int          bp_mode = 0;  // 0: always ready, 1: random, 2: held low
   logic        prev_hold = 1'b0;
   logic [15:0] prev_p;
   logic [3:0]  prev_f;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer back-pressure.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 9) < 7);
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   // Reference model: exact integer product, rounded by remainder comparison.
   function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic   s, an, bn, ai, bi, az, bz, asn, bsn;
      int     ea, eb, ma, mb, e, sh, msb;
      longint p, q, rem, half;
      s   = a[15] ^ b[15];
      ea  = int'(a[14:10]);
      eb  = int'(b[14:10]);
      ma  = int'(a[9:0]);
      mb  = int'(b[9:0]);
      an  = (ea == 31) && (ma != 0);
      bn  = (eb == 31) && (mb != 0);
      ai  = (ea == 31) && (ma == 0);
      bi  = (eb == 31) && (mb == 0);
      az  = (ea == 0);
      bz  = (eb == 0);
      asn = an && (ma < 512);
      bsn = bn && (mb < 512);
      if (an || bn) return {16'h7E00, 3'b000, asn || bsn};
      if ((ai && bz) || (bi && az)) return {16'h7E00, 4'b0001};
      if (ai || bi) return {s, 5'h1F, 10'h000, 4'b0000};
      if (az || bz) return {s, 15'h0000, 4'b0000};
      p    = longint'(1024 + ma) * longint'(1024 + mb);
      msb  = (p >= 64'd2097152) ? 21 : 20;
      sh   = msb - 10;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      e = ea + eb - 15 + (msb - 20);
      if (q == 2048) begin
         q = 1024;
         e = e + 1;
      end
      if (e >= 31) return {s, 5'h1F, 10'h000, 4'b1010};
      if (e <= 0) return {s, 15'h0000, 4'b0110};
      return {s, 5'(e), 10'(q), 2'b00, rem != 0, 1'b0};
   endfunction

   function automatic logic [15:0] rnd_op();
      int         c;
      logic [4:0] e;
      logic [9:0] m;
      c = $urandom_range(0, 15);
      m = 10'($urandom);
      e = 5'($urandom_range(1, 30));
      case (c)
         0:       e = 5'd0;
         1:       begin e = 5'd31; m = 10'd0; end
         2:       begin e = 5'd31; if (m == 10'd0) m = 10'd1; end
         3, 4, 5: e = 5'($urandom_range(8, 22));
         6:       m = 10'h3FF;
         default: ;
      endcase
      return {1'($urandom), e, m};
   endfunction

   // Present one operand pair until accepted; record its expected result on acceptance.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [19:0] ex);
      int   tries;
      exp_t e;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      tries        = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.prod       = ex[19:4];
            e.flags      = ex[3:0];
            e.acc_cyc    = cyc;
            e.acc_stalls = stalls;
            exp_q.push_back(e);
            break;
         end
         tries++;
         if (tries > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready stuck at 0, want 1 within 200 cycles");
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < 400)) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s drain: %0d results outstanding, want 0", tag, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s out_valid got %b want 0", tag, bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s in_ready got %b want 1", tag, bus.in_ready);
      end
      checks++;
      if (bus.product !== 16'h0000) begin
         errors++;
         $display("FAIL %s product got %h want 0000", tag, bus.product);
      end
      checks++;
      if ({bus.overflow, bus.underflow, bus.inexact, bus.invalid} !== 4'b0000) begin
         errors++;
         $display("FAIL %s flags got %b want 0000", tag,
                  {bus.overflow, bus.underflow, bus.inexact, bus.invalid});
      end
   endtask

   // Monitor: handshake rule, hold-while-stalled, in-order results and latency.
   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [3:0] f;
      f = {bus.overflow, bus.underflow, bus.inexact, bus.invalid};
      if (!rst_n) begin
         exp_q.delete();
         prev_hold = 1'b0;
      end else begin
         checks++;
         if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
            errors++;
            $display("FAIL in_ready got %b want %b", bus.in_ready,
                     !bus.out_valid || bus.out_ready);
         end
         if (prev_hold) begin
            checks++;
            if ((bus.out_valid !== 1'b1) || (bus.product !== prev_p) || (f !== prev_f)) begin
               errors++;
               $display("FAIL hold got v=%b %h/%b want v=1 %h/%b", bus.out_valid,
                        bus.product, f, prev_p, prev_f);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected result %h/%b, want no output", bus.product, f);
            end else begin
               e = exp_q.pop_front();
               if ((bus.product !== e.prod) || (f !== e.flags)) begin
                  errors++;
                  $display("FAIL result got %h/%b want %h/%b", bus.product, f, e.prod,
                           e.flags);
               end
               if (e.acc_stalls == stalls) begin
                  checks++;
                  if (cyc - e.acc_cyc != 4) begin
                     errors++;
                     $display("FAIL latency got %0d want 4", cyc - e.acc_cyc);
                  end
               end
            end
         end
         if (bus.out_valid && !bus.out_ready) stalls++;
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_p    = bus.product;
         prev_f    = f;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, want $finish");
      $fatal(1);
   end

   logic [15:0] dir_a[11];
   logic [15:0] dir_b[11];
   logic [19:0] dir_x[11];

   initial begin
      int          n;
      logic [15:0] ra, rb;
      dir_a = '{16'h3C00, 16'h3C01, 16'h3C00, 16'h7BFF, 16'h0400, 16'h7C00,
                16'h7E00, 16'h0001, 16'h7D00, 16'h7C00, 16'h8000};
      dir_b = '{16'h3C00, 16'h3C01, 16'hBC00, 16'h4000, 16'h0400, 16'h0000,
                16'h3C00, 16'h3C00, 16'h3C00, 16'hC000, 16'h7BFF};
      dir_x = '{{16'h3C00, 4'b0000}, {16'h3C02, 4'b0010}, {16'hBC00, 4'b0000},
                {16'h7C00, 4'b1010}, {16'h0000, 4'b0110}, {16'h7E00, 4'b0001},
                {16'h7E00, 4'b0000}, {16'h0000, 4'b0000}, {16'h7E00, 4'b0001},
                {16'hFC00, 4'b0000}, {16'h8000, 4'b0000}};
      bus.in_valid    = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      bus32.in_valid  = 1'b0;
      bus32.a         = '0;
      bus32.b         = '0;
      bus32.out_ready = 1'b1;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("reset");
      @(posedge clk);
      #1;

      // Directed vectors with known answers, issued back to back.
      for (int i = 0; i < 11; i++) send(dir_a[i], dir_b[i], dir_x[i]);
      wait_drain("directed");

      // Single-precision configuration smoke test.
      bus32.in_valid = 1'b1;
      bus32.a        = 32'h3F800000;
      bus32.b        = 32'h40000000;
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (bus32.out_valid) break;
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL sp_latency got %0d want 4", n);
      end
      checks++;
      if ((bus32.product !== 32'h40000000) ||
          ({bus32.overflow, bus32.underflow, bus32.inexact, bus32.invalid} !== 4'b0000)) begin
         errors++;
         $display("FAIL sp_result got %h/%b want 40000000/0000", bus32.product,
                  {bus32.overflow, bus32.underflow, bus32.inexact, bus32.invalid});
      end
      @(posedge clk);
      #1;

      // Six back-to-back pairs with a three-cycle consumer stall mid-stream.
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               ra = rnd_op();
               rb = rnd_op();
               send(ra, rb, ref_mul(ra, rb));
            end
         end
         begin
            repeat (5) @(posedge clk);
            bp_mode = 2;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready got %b want 0", bus.in_ready);
            end
            @(posedge clk);
            @(posedge clk);
            bp_mode = 0;
         end
      join
      wait_drain("stall");

      // Reset pulse with three operations in flight: none of them may emerge.
      for (int i = 0; i < 3; i++) begin
         ra = rnd_op();
         rb = rnd_op();
         send(ra, rb, ref_mul(ra, rb));
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("midreset");
      repeat (8) @(posedge clk);
      #1;
      send(16'h4000, 16'h4200, {16'h4600, 4'b0000});
      wait_drain("after_reset");

      // Randomised traffic under random back-pressure and input gaps.
      bp_mode = 1;
      for (int i = 0; i < 400; i++) begin
         ra = rnd_op();
         rb = rnd_op();
         send(ra, rb, ref_mul(ra, rb));
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      bp_mode = 0;
      wait_drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpmul_pipe.md
FPMUL_PIPE -- requirements
Module: fpmul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width (range 3..11).
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa field width (range 2..52).
REQ-003 SHALL derive localparams W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1 and EMAX = 2^EXP_W-1.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 in_valid  input  1  the A/B operand pair is valid.
REQ-008 in_ready  output  1  the block accepts an operand pair this cycle.
REQ-009 A, B  input  W each  operands: {sign, exponent, mantissa}.
REQ-010 out_valid  output  1  Product and flags are valid.
REQ-011 out_ready  input  1  the consumer accepts the result this cycle.
REQ-012 Product  output  W  result.
REQ-013 overflow, underflow, inexact, invalid  output  1 each  exception flags qualified by out_valid.

Function
REQ-014 SHALL be a 4-stage pipeline: S1 operand register, S2 unpack/special-case/multiply, S3 normalise/round, S4 output register; each stage SHALL carry a valid bit.
REQ-015 advance = !out_valid || out_ready; all stages SHALL shift only when advance=1 and SHALL hold otherwise.
REQ-016 in_ready SHALL equal advance; an operand pair is accepted when in_valid && in_ready.
REQ-017 Latency SHALL be exactly 4 cycles from acceptance to out_valid when no stall occurs; throughput SHALL be 1 result per cycle.
REQ-018 Results SHALL emerge in acceptance order, with none dropped or duplicated under any out_ready pattern.
REQ-019 Product and the flags SHALL stay stable while out_valid && !out_ready.
REQ-020 Subnormal inputs (exp=0, mant!=0) SHALL be treated as signed zero (DAZ).
REQ-021 Sign SHALL be A.sign XOR B.sign for every non-NaN result.
REQ-022 The significand product SHALL be {1,mA} * {1,mB}, 2*MAN_W+2 bits wide; if its MSB is set, it SHALL shift right 1 and the exponent SHALL increment.
REQ-023 Unbiased exponent sum eA+eB-BIAS SHALL be computed at EXP_W+2 bits signed, with no wrap.
REQ-024 Rounding SHALL be round-to-nearest-even using guard plus sticky (OR of all lower bits); a rounding carry SHALL renormalise and increment the exponent.
REQ-025 inexact SHALL be set when guard or sticky is 1, or when an overflow or underflow result is produced.
REQ-026 If the final exponent is >= EMAX, the result SHALL be signed infinity (exp=EMAX, mant=0) with overflow=1 and inexact=1.
REQ-027 If the final exponent is <= 0 and the product is nonzero, the result SHALL be signed zero (FTZ) with underflow=1 and inexact=1.
REQ-028 Zero times finite SHALL give signed zero with all flags 0.
REQ-029 Infinity times nonzero finite or infinity SHALL give signed infinity with all flags 0.
REQ-030 Infinity times zero SHALL give canonical qNaN {0, EMAX, 1 followed by 0s} with invalid=1.
REQ-031 Any NaN input SHALL give the canonical qNaN with invalid=1 only if either input is a signalling NaN (mantissa MSB=0).
REQ-032 Special-case detection SHALL override the arithmetic path; overflow, underflow and inexact SHALL be 0 for special cases.

Reset
REQ-033 While rst_n=0 at a clk edge, all stage valid bits, out_valid, Product and the flags SHALL be cleared to 0.
REQ-034 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after reset.
REQ-035 in_ready SHALL be 1 in the first cycle after reset release (pipeline empty, out_valid=0).
REQ-036 Datapath-only registers (non-valid, non-output) need no reset.

Verification
REQ-037 Default params, A=0x3C00, B=0x3C00, out_ready=1 -> Product=0x3C00, all flags 0, out_valid exactly 4 cycles after acceptance.
REQ-038 A=0x3C01, B=0x3C01 -> 0x3C02, inexact=1; A=0x3C00, B=0xBC00 -> 0xBC00, no flags.
REQ-039 A=0x7BFF, B=0x4000 -> 0x7C00, overflow=1, inexact=1; A=0x0400, B=0x0400 -> 0x0000, underflow=1, inexact=1.
REQ-040 A=0x7C00, B=0x0000 -> 0x7E00, invalid=1; A=0x7E00, B=0x3C00 -> 0x7E00, invalid=0; A=0x0001, B=0x3C00 -> 0x0000, no flags.
REQ-041 Six back-to-back pairs with out_ready low for 3 cycles mid-stream -> in_ready low during the stall, six results in order, Product held stable.
REQ-042 rst_n pulsed low for one cycle with 3 ops in flight -> no out_valid for those ops; a fresh op completes in 4 cycles; EXP_W=8/MAN_W=23 smoke test: 0x3F800000 * 0x40000000 -> 0x40000000.
